// File: rtl/regfile_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_if
//   Bundles the write-back arbiter's bus signals. Signal names are written
//   from the arbiter's point of view (i_ = into the arbiter, o_ = out of it).
//
//   Load handshake: a load result transfers on a rising clk edge where
//   i_ld_valid and o_ld_ready are both high. o_ld_ready depends only on
//   registered state and reset, never on i_ld_valid or i_alu_valid. Once
//   asserted, i_ld_valid is held with stable addr/data until the transfer.
//
//   Ports (signals):
//     i_alu_valid/i_alu_addr/i_alu_data : single-cycle ALU result
//     i_ld_valid/o_ld_ready/i_ld_addr/i_ld_data : load result handshake
//     o_wr_en/o_wr_addr/o_wr_data : registered register-file write port
//     i_q_addr/o_q_pending : hazard query
//     o_r15_drop : one-cycle pulse when a write to r15 is discarded
//     o_fifo_count : load FIFO occupancy
//   Modports: slave = arbiter, master = core / stimulus side.
// -----------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
);
   logic          i_alu_valid;
   logic [3:0]    i_alu_addr;
   logic [15:0]   i_alu_data;
   logic          i_ld_valid;
   logic          o_ld_ready;
   logic [3:0]    i_ld_addr;
   logic [15:0]   i_ld_data;
   logic          o_wr_en;
   logic [3:0]    o_wr_addr;
   logic [15:0]   o_wr_data;
   logic [3:0]    i_q_addr;
   logic          o_q_pending;
   logic          o_r15_drop;
   logic [CW-1:0] o_fifo_count;

   modport slave (
      input  i_alu_valid, i_alu_addr, i_alu_data,
      input  i_ld_valid, i_ld_addr, i_ld_data,
      output o_ld_ready,
      output o_wr_en, o_wr_addr, o_wr_data,
      input  i_q_addr,
      output o_q_pending, o_r15_drop, o_fifo_count
   );

   modport master (
      output i_alu_valid, i_alu_addr, i_alu_data,
      output i_ld_valid, i_ld_addr, i_ld_data,
      input  o_ld_ready,
      input  o_wr_en, o_wr_addr, o_wr_data,
      output i_q_addr,
      input  o_q_pending, o_r15_drop, o_fifo_count
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//   Merges ALU results and load results onto the single register-file write
//   port. ALU results always win and are never stalled; load results wait in
//   an in-order FIFO and drain on cycles where the ALU does not write.
//   Register 15 is the PC alias: writes to it are discarded and reported on
//   o_r15_drop. o_q_pending tells the core whether a write to a register is
//   still queued or currently on the write port.
//
//   Ports:
//     clk   : system clock
//     reset : synchronous, active-high; flushes queued loads
//     bus   : regfile_wb_arbiter_if.slave (see interface header)
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input logic                  clk,
   input logic                  reset,
   regfile_wb_arbiter_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] PC_ADDR = 4'd15;

   // FIFO storage and bookkeeping
   logic [3:0]    r_fifo_addr [DEPTH];
   logic [15:0]   r_fifo_data [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   // Write port and drop pulse
   logic          r_wr_en;
   logic [3:0]    r_wr_addr;
   logic [15:0]   r_wr_data;
   logic          r_r15_drop;

   logic          w_ld_ready;
   logic          w_ld_fire;
   logic          w_push;
   logic          w_ld_drop;
   logic          w_alu_wr;
   logic          w_alu_drop;
   logic          w_pop;
   logic [AW-1:0] w_off [DEPTH];
   logic          w_fifo_hit;
   logic          w_port_hit;

   // Ready comes only from the occupancy register, so a same-cycle pop never
   // makes room for a push when full.
   assign w_ld_ready = !reset && (r_count != CW'(DEPTH));
   assign w_ld_fire  = bus.i_ld_valid && w_ld_ready;
   assign w_push     = w_ld_fire && (bus.i_ld_addr != PC_ADDR);
   assign w_ld_drop  = w_ld_fire && (bus.i_ld_addr == PC_ADDR);

   assign w_alu_wr   = bus.i_alu_valid && (bus.i_alu_addr != PC_ADDR);
   assign w_alu_drop = bus.i_alu_valid && (bus.i_alu_addr == PC_ADDR);

   // A dropped ALU write leaves the port free, so the FIFO may drain then.
   assign w_pop      = !w_alu_wr && (r_count != '0);

   // An entry is live when its distance from the read pointer is below the
   // occupancy; stale slots beyond that must not raise a hazard.
   always_comb begin
      w_fifo_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         w_off[i] = AW'(i) - r_rd_ptr;
         if ((CW'(w_off[i]) < r_count) && (r_fifo_addr[i] == bus.i_q_addr)) begin
            w_fifo_hit = 1'b1;
         end
      end
   end

   assign w_port_hit = r_wr_en && (r_wr_addr == bus.i_q_addr);

   // Storage needs no reset: occupancy decides which slots are meaningful.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_addr[r_wr_ptr] <= bus.i_ld_addr;
         r_fifo_data[r_wr_ptr] <= bus.i_ld_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_r15_drop <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase

         // Both drop sources can fire together; they merge into one pulse.
         r_r15_drop <= w_alu_drop || w_ld_drop;

         if (w_alu_wr) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= bus.i_alu_addr;
            r_wr_data <= bus.i_alu_data;
         end else if (w_pop) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_fifo_addr[r_rd_ptr];
            r_wr_data <= r_fifo_data[r_rd_ptr];
         end else begin
            // Address/data hold their last values while idle.
            r_wr_en   <= 1'b0;
         end
      end
   end

   assign bus.o_ld_ready   = w_ld_ready;
   assign bus.o_wr_en      = r_wr_en;
   assign bus.o_wr_addr    = r_wr_addr;
   assign bus.o_wr_data    = r_wr_data;
   assign bus.o_r15_drop   = r_r15_drop;
   assign bus.o_fifo_count = r_count;
   // r15 is never queued nor written, but the query is forced low regardless.
   assign bus.o_q_pending  = (bus.i_q_addr != PC_ADDR) && (w_fifo_hit || w_port_hit);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//   Cycle table: each record holds the inputs applied for one cycle and the
//   outputs expected in that same cycle (registered outputs show the result
//   of the previous edge). Inputs change on the falling edge, outputs are
//   sampled 1ns later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic clk;
   logic reset;

   regfile_wb_arbiter_if #(.DEPTH(DEPTH), .CW(CW)) bus ();

   regfile_wb_arbiter #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        alu_v;
      logic [3:0]  alu_a;
      logic [15:0] alu_d;
      logic        ld_v;
      logic [3:0]  ld_a;
      logic [15:0] ld_d;
      logic [3:0]  q_a;
      logic        e_rdy;
      logic        e_wen;
      logic [3:0]  e_wa;
      logic [15:0] e_wd;
      logic        e_qp;
      logic        e_drop;
      logic [2:0]  e_cnt;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic void add_v(
      input logic rst, input logic av, input logic [3:0] aa, input logic [15:0] ad,
      input logic lv, input logic [3:0] la, input logic [15:0] ld, input logic [3:0] q,
      input logic rdy, input logic wen, input logic [3:0] wa, input logic [15:0] wd,
      input logic qp, input logic drop, input logic [2:0] cnt);
      vec_t v;
      v.rst = rst; v.alu_v = av; v.alu_a = aa; v.alu_d = ad;
      v.ld_v = lv; v.ld_a = la; v.ld_d = ld; v.q_a = q;
      v.e_rdy = rdy; v.e_wen = wen; v.e_wa = wa; v.e_wd = wd;
      v.e_qp = qp; v.e_drop = drop; v.e_cnt = cnt;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input int idx,
                        input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      reset           = v.rst;
      bus.i_alu_valid = v.alu_v;
      bus.i_alu_addr  = v.alu_a;
      bus.i_alu_data  = v.alu_d;
      bus.i_ld_valid  = v.ld_v;
      bus.i_ld_addr   = v.ld_a;
      bus.i_ld_data   = v.ld_d;
      bus.i_q_addr    = v.q_a;
   endtask

   task automatic idle_inputs();
      bus.i_alu_valid = 1'b0;
      bus.i_alu_addr  = '0;
      bus.i_alu_data  = '0;
      bus.i_ld_valid  = 1'b0;
      bus.i_ld_addr   = '0;
      bus.i_ld_data   = '0;
      bus.i_q_addr    = '0;
   endtask

   // Safety net against a hung run.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running, expected done");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      reset = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);

      //     rst av aa  ad        lv la  ld        q    rdy wen wa  wd        qp drop cnt
      // Reset state
      add_v(1, 0, 0,  16'h0000, 0, 0,  16'h0000, 0,   0, 0, 0,  16'h0000, 0, 0, 0);
      // Single ALU write
      add_v(0, 1, 3,  16'hBEEF, 0, 0,  16'h0000, 3,   1, 0, 0,  16'h0000, 0, 0, 0);
      add_v(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 3,   1, 1, 3,  16'hBEEF, 1, 0, 0);
      add_v(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 3,   1, 0, 3,  16'hBEEF, 0, 0, 0);
      // Single load: written two cycles after acceptance
      add_v(0, 0, 0,  16'h0000, 1, 5,  16'h1234, 5,   1, 0, 3,  16'hBEEF, 0, 0, 0);
      add_v(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 5,   1, 0, 3,  16'hBEEF, 1, 0, 1);
      add_v(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 5,   1, 1, 5,  16'h1234, 1, 0, 0);
      add_v(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 5,   1, 0, 5,  16'h1234, 0, 0, 0);
      // ALU stream 1..6 while loads 8..13 fill and back-pressure the FIFO
      add_v(0, 1, 1,  16'hA001, 1, 8,  16'hD008, 8,   1, 0, 5,  16'h1234, 0, 0, 0);
      add_v(0, 1, 2,  16'hA002, 1, 9,  16'hD009, 8,   1, 1, 1,  16'hA001, 1, 0, 1);
      add_v(0, 1, 3,  16'hA003, 1, 10, 16'hD00A, 8,   1, 1, 2,  16'hA002, 1, 0, 2);
      add_v(0, 1, 4,  16'hA004, 1, 11, 16'hD00B, 8,   1, 1, 3,  16'hA003, 1, 0, 3);
      add_v(0, 1, 5,  16'hA005, 1, 12, 16'hD00C, 8,   0, 1, 4,  16'hA004, 1, 0, 4);
      add_v(0, 1, 6,  16'hA006, 1, 12, 16'hD00C, 8,   0, 1, 5,  16'hA005, 1, 0, 4);
      add_v(0, 0, 0,  16'h0000, 1, 12, 16'hD00C, 8,   0, 1, 6,  16'hA006, 1, 0, 4);
      add_v(0, 0, 0,  16'h0000, 1, 12, 16'hD00C, 8,   1, 1, 8,  16'hD008, 1, 0, 3);
      add_v(0, 0, 0,  16'h0000, 1, 13, 16'hD00D, 8,   1, 1, 9,  16'hD009, 0, 0, 3);
      add_v(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 13,  1, 1, 10, 16'hD00A, 1, 0, 3);
      add_v(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 13,  1, 1, 11, 16'hD00B, 1, 0, 2);
      add_v(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 13,  1, 1, 12, 16'hD00C, 1, 0, 1);
      add_v(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 13,  1, 1, 13, 16'hD00D, 1, 0, 0);
      add_v(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 13,  1, 0, 13, 16'hD00D, 0, 0, 0);
      // r15 drops from both sources in one cycle, FIFO still drains
      add_v(0, 0, 0,  16'h0000, 1, 7,  16'h7777, 7,   1, 0, 13, 16'hD00D, 0, 0, 0);
      add_v(0, 1, 15, 16'hFFFF, 1, 15, 16'h5555, 7,   1, 0, 13, 16'hD00D, 1, 0, 1);
      add_v(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 7,   1, 1, 7,  16'h7777, 1, 1, 0);
      add_v(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 7,   1, 0, 7,  16'h7777, 0, 0, 0);
      // Fill FIFO under ALU pressure, then reset flushes it
      add_v(0, 1, 1,  16'h1111, 1, 2,  16'hE002, 2,   1, 0, 7,  16'h7777, 0, 0, 0);
      add_v(0, 1, 1,  16'h1111, 1, 3,  16'hE003, 2,   1, 1, 1,  16'h1111, 1, 0, 1);
      add_v(0, 1, 1,  16'h1111, 1, 4,  16'hE004, 2,   1, 1, 1,  16'h1111, 1, 0, 2);
      add_v(0, 1, 1,  16'h1111, 1, 5,  16'hE005, 2,   1, 1, 1,  16'h1111, 1, 0, 3);
      add_v(1, 1, 1,  16'h1111, 1, 6,  16'hE006, 2,   0, 1, 1,  16'h1111, 1, 0, 4);
      add_v(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 2,   1, 0, 0,  16'h0000, 0, 0, 0);
      add_v(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 2,   1, 0, 0,  16'h0000, 0, 0, 0);
      // Push and pop every cycle across two pointer wraps
      for (int k = 0; k <= 2 * DEPTH + 1; k++) begin
         logic [3:0]  qk;
         logic        wen_k;
         logic [3:0]  wa_k;
         logic [15:0] wd_k;
         qk    = (k == 0) ? 4'd0 : 4'(k - 1);
         wen_k = (k >= 2);
         wa_k  = (k >= 2) ? 4'(k - 2) : 4'd0;
         wd_k  = (k >= 2) ? 16'hC000 + 16'(k - 2) : 16'h0000;
         add_v(0, 0, 0, 16'h0000, 1, 4'(k), 16'hC000 + 16'(k), qk,
               1, wen_k, wa_k, wd_k, (k != 0), 0, (k == 0) ? 3'd0 : 3'd1);
      end
      add_v(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 9,   1, 1, 8,  16'hC008, 1, 0, 1);
      add_v(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 9,   1, 1, 9,  16'hC009, 1, 0, 0);
      add_v(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 9,   1, 0, 9,  16'hC009, 0, 0, 0);

      foreach (vecs[i]) begin
         drive(vecs[i]);
         #1;
         check("ld_ready",   i, 16'(bus.o_ld_ready),   16'(vecs[i].e_rdy));
         check("wr_en",      i, 16'(bus.o_wr_en),      16'(vecs[i].e_wen));
         check("wr_addr",    i, 16'(bus.o_wr_addr),    16'(vecs[i].e_wa));
         check("wr_data",    i, bus.o_wr_data,         vecs[i].e_wd);
         check("q_pending",  i, 16'(bus.o_q_pending),  16'(vecs[i].e_qp));
         check("r15_drop",   i, 16'(bus.o_r15_drop),   16'(vecs[i].e_drop));
         check("fifo_count", i, 16'(bus.o_fifo_count), 16'(vecs[i].e_cnt));
         @(posedge clk);
         @(negedge clk);
      end

      // Load latency measured with a bounded wait: one edge to accept,
      // one more to pop into the write port.
      idle_inputs();
      bus.i_ld_valid = 1'b1;
      bus.i_ld_addr  = 4'd9;
      bus.i_ld_data  = 16'h5A5A;
      #1;
      check("lat_ready", 1000, 16'(bus.o_ld_ready), 16'd1);
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      n = 0;
      for (int c = 1; c <= 8; c++) begin
         #1;
         if (bus.o_wr_en) begin
            n = c;
            break;
         end
         @(posedge clk);
         @(negedge clk);
      end
      check("lat_edges",   1001, 16'(n), 16'd2);
      check("lat_wr_addr", 1002, 16'(bus.o_wr_addr), 16'd9);
      check("lat_wr_data", 1003, bus.o_wr_data, 16'h5A5A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-side initiator for the 16-bit core register file: merges ALU and load-unit results into the register file's single write port (wr_en/wr_addr/wr_data).
- ALU results are single-cycle and are never back-pressured.
- Load results are buffered in a small in-order FIFO and drain on cycles when the ALU does not write.
- Address 15 aliases the PC, is read-only, and writes to it are dropped. A pending-write query supports the core's hazard/stall logic.

Parameters:
- DEPTH, 4, load FIFO entries; power of two, >= 2.
- CW, $clog2(DEPTH)+1, width of fifo_count.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- alu_valid  in  1  ALU result present this cycle
- alu_addr  in  4  ALU destination register
- alu_data  in  16  ALU result
- ld_valid  in  1  load result offered
- ld_ready  out  1  FIFO can accept a load result
- ld_addr  in  4  load destination register
- ld_data  in  16  load data
- wr_en  out  1  register-file write enable (registered)
- wr_addr  out  4  register-file write address (registered)
- wr_data  out  16  register-file write data (registered)
- q_addr  in  4  hazard query address
- q_pending  out  1  a write to q_addr is queued or in flight
- r15_drop  out  1  one-cycle pulse: a write to r15 was discarded
- fifo_count  out  CW  current FIFO occupancy

Behaviour:
- Reset (synchronous, dominant over all other inputs):
  - wr_en=0, wr_addr=0, wr_data=0, r15_drop=0, fifo_count=0, FIFO pointers=0.
  - ld_ready=0 while reset is high.
  - Reset mid-operation flushes all queued loads with no write issued.
- Load handshake:
  - Transfer occurs when ld_valid & ld_ready at a clock edge.
  - ld_ready = !reset & (fifo_count != DEPTH). It depends only on registered state, with no combinational path from ld_valid or alu_valid.
  - When full, ld_ready=0 even if a pop happens the same cycle.
- Load with ld_addr==15: handshake completes, nothing is enqueued, r15_drop=1 in the next cycle.
- Per-cycle select (combinational), registered into wr_* at the edge:
  - First priority: alu_valid & alu_addr!=15 -> ALU result.
  - Otherwise, if the FIFO is non-empty -> pop the head entry.
  - Otherwise -> wr_en=0 next cycle; wr_addr/wr_data hold their previous values.
- alu_valid with alu_addr==15: no write, r15_drop=1 in the next cycle, and a FIFO pop is allowed that cycle.
- Latency:
  - ALU result: wr_en asserts 1 cycle after alu_valid.
  - Load accepted at edge E: earliest pop is in the cycle after E, so wr_en asserts 2 cycles after acceptance.
  - Loads have no bypass path.
- Simultaneous push and pop on a non-empty FIFO: fifo_count is unchanged, pointers advance, and wrap modulo DEPTH.
- Ordering:
  - FIFO entries drain strictly in order.
  - The ALU may overtake queued loads. This block does not resolve WAW ordering; the core stalls using q_pending.
- q_pending (combinational) is 1 if either condition holds:
  - any valid FIFO entry has addr==q_addr;
  - wr_en & wr_addr==q_addr.
- q_pending is forced to 0 when q_addr==15.
- r15_drop: OR of both drop sources; at most one pulse per cycle.

Test Plan:
- Reset, then alu_valid=1, alu_addr=3, alu_data=16'hBEEF for one cycle -> next cycle wr_en=1, wr_addr=3, wr_data=16'hBEEF; following cycle wr_en=0; fifo_count=0 throughout.
- Load addr=5, data=16'h1234 accepted with the ALU idle -> fifo_count=1 for one cycle; wr_en=1, wr_addr=5 two cycles after acceptance; q_pending=1 for q_addr=5 from the cycle after acceptance until the write cycle ends.
- alu_valid held high to addrs 1..6 for 6 cycles while loads to addrs 8..13 are offered -> ld_ready drops after 4 accepted (fifo_count=4). All ALU writes appear with no gaps, then the loads write 8,9,10,11 in order, then 12 and 13 after ready reasserts.
- alu_addr=15 with the FIFO holding addr=7 -> next cycle r15_drop=1 and wr_en=1, wr_addr=7. Same cycle, also accept a load to addr 15 -> single r15_drop pulse, fifo_count unchanged by that load.
- FIFO full (4 entries), reset asserted for one cycle -> wr_en=0, fifo_count=0, ld_ready=0 during reset and 1 after; no queued entry is ever written.
- Push and pop in the same cycle for 2*DEPTH+1 cycles -> fifo_count stays at 1, data emerges in order across pointer wrap.
